// File: rtl/key_debounce_pulse.sv
// key_debounce_pulse: per-bit sync, debounce, level and press/release pulses.
// Optional auto-repeat on held keys when KEY_AUTOREPEAT_EN is defined.
module key_debounce_pulse #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic             CLOCK,
  input  logic             RST_n,
  input  logic [WIDTH-1:0] iKEY,
  output logic [WIDTH-1:0] oKEY_LEVEL,
  output logic [WIDTH-1:0] oPRESS,
  output logic [WIDTH-1:0] oRELEASE
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

`ifdef KEY_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                        REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);
  localparam logic [RW-1:0] RPT_ONE  = RW'(1);
`endif

  typedef enum logic [1:0] {
    RELEASED  = 2'd0,
`ifdef KEY_AUTOREPEAT_EN
    REPEATING = 2'd2,
`endif
    PRESSED   = 2'd1
  } state_e;

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] level_q, level_d;
  logic [WIDTH-1:0] press_q, press_d;
  logic [WIDTH-1:0] rel_q,   rel_d;

  logic [CW-1:0] cnt_q   [WIDTH];
  logic [CW-1:0] cnt_d   [WIDTH];
  state_e        state_q [WIDTH];
  state_e        state_d [WIDTH];

`ifdef KEY_AUTOREPEAT_EN
  logic [RW-1:0] rpt_q [WIDTH];
  logic [RW-1:0] rpt_d [WIDTH];
`endif

  // Next-state: sync shift, stability count, acceptance and pulses.
  always_comb begin
    sync1_d = iKEY;
    sync2_d = sync1_q;
    level_d = level_q;
    press_d = '0;
    rel_d   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i]   = cnt_q[i];
      state_d[i] = state_q[i];
`ifdef KEY_AUTOREPEAT_EN
      rpt_d[i]   = rpt_q[i];
      // Held-key repeat timing; an accepted release below overrides it.
      unique case (state_q[i])
        PRESSED: begin
          if (rpt_q[i] == DLY_LAST) begin
            press_d[i] = 1'b1;
            state_d[i] = REPEATING;
            rpt_d[i]   = '0;
          end else begin
            rpt_d[i]   = rpt_q[i] + RPT_ONE;
          end
        end
        REPEATING: begin
          if (rpt_q[i] == PER_LAST) begin
            press_d[i] = 1'b1;
            rpt_d[i]   = '0;
          end else begin
            rpt_d[i]   = rpt_q[i] + RPT_ONE;
          end
        end
        default: begin
          rpt_d[i] = '0;
        end
      endcase
`endif
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          cnt_d[i]   = '0;
          level_d[i] = sync2_q[i];
`ifdef KEY_AUTOREPEAT_EN
          rpt_d[i]   = '0;
`endif
          if (sync2_q[i]) begin
            rel_d[i]   = 1'b1;
            press_d[i] = 1'b0;
            state_d[i] = RELEASED;
          end else begin
            press_d[i] = 1'b1;
            state_d[i] = PRESSED;
          end
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  // State registers; reset parks every bit released and silent.
  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
      level_q <= '1;
      press_q <= '0;
      rel_q   <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i]   <= '0;
        state_q[i] <= RELEASED;
`ifdef KEY_AUTOREPEAT_EN
        rpt_q[i]   <= '0;
`endif
      end
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i]   <= cnt_d[i];
        state_q[i] <= state_d[i];
`ifdef KEY_AUTOREPEAT_EN
        rpt_q[i]   <= rpt_d[i];
`endif
      end
    end
  end

  assign oKEY_LEVEL = level_q;
  assign oPRESS     = press_q;
  assign oRELEASE   = rel_q;

endmodule

// File: tb/tb_key_debounce_pulse.sv
// tb_key_debounce_pulse: scoreboard bench for key_debounce_pulse.
// Expected pulses are queued by stimulus and popped by a monitor.
module tb_key_debounce_pulse;

  localparam int W  = 4;
  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 3;
  localparam int LAT = D + 2;

  logic         CLOCK = 1'b0;
  logic         RST_n = 1'b0;
  logic [W-1:0] iKEY  = '1;
  logic [W-1:0] oKEY_LEVEL;
  logic [W-1:0] oPRESS;
  logic [W-1:0] oRELEASE;

  key_debounce_pulse #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .CLOCK     (CLOCK),
    .RST_n     (RST_n),
    .iKEY      (iKEY),
    .oKEY_LEVEL(oKEY_LEVEL),
    .oPRESS    (oPRESS),
    .oRELEASE  (oRELEASE)
  );

  always #5 CLOCK = ~CLOCK;

  int cyc = 0;
  always @(posedge CLOCK) cyc++;

  typedef struct {
    int         c;
    logic [3:0] p;
    logic [3:0] r;
    logic [3:0] lv;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at cyc=%0d",
               nm, act, want, cyc);
    end
  endtask

  task automatic push_at(input int c, input logic [3:0] p,
                         input logic [3:0] r, input logic [3:0] lv);
    exp_t e;
    e.c  = c;
    e.p  = p;
    e.r  = r;
    e.lv = lv;
    q.push_back(e);
  endtask

  task automatic push(input logic [3:0] p, input logic [3:0] r,
                      input logic [3:0] lv);
    push_at(cyc + LAT, p, r, lv);
  endtask

  task automatic wn(input int n);
    repeat (n) @(negedge CLOCK);
  endtask

  // Monitor: every pulse cycle must match the head of the queue.
  always @(negedge CLOCK) begin
    if (RST_n && ((oPRESS | oRELEASE) != '0)) begin
      if (q.size() == 0) begin
        chk("unexpected_pulse", {24'd0, oPRESS, oRELEASE}, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pulse_cycle", cyc, e.c);
        chk("press", {28'd0, oPRESS}, {28'd0, e.p});
        chk("release", {28'd0, oRELEASE}, {28'd0, e.r});
        chk("level", {28'd0, oKEY_LEVEL}, {28'd0, e.lv});
      end
    end
  end

  initial begin
    // reset with all keys held down
    RST_n = 1'b0;
    iKEY  = 4'b0000;
    wn(3);
    chk("rst_level", {28'd0, oKEY_LEVEL}, 32'hF);
    chk("rst_press", {28'd0, oPRESS}, 32'h0);
    chk("rst_release", {28'd0, oRELEASE}, 32'h0);
    RST_n = 1'b1;
    push(4'b1111, 4'b0000, 4'b0000);
    wn(10);
    iKEY = 4'b1111;
    push(4'b0000, 4'b1111, 4'b1111);
    wn(10);

    // clean press and release on bit 0
    iKEY = 4'b1110;
    push(4'b0001, 4'b0000, 4'b1110);
    wn(10);
    iKEY = 4'b1111;
    push(4'b0000, 4'b0001, 4'b1111);
    wn(10);

    // bounce on bit 1 before settling low
    iKEY = 4'b1101;
    wn(3);
    iKEY = 4'b1111;
    wn(3);
    iKEY = 4'b1101;
    wn(3);
    iKEY = 4'b1111;
    wn(3);
    iKEY = 4'b1101;
    push(4'b0010, 4'b0000, 4'b1101);
    wn(10);
    iKEY = 4'b1111;
    push(4'b0000, 4'b0010, 4'b1111);
    wn(10);

    // simultaneous press on bits 1 and 3
    iKEY = 4'b0101;
    push(4'b1010, 4'b0000, 4'b0101);
    wn(10);
    iKEY = 4'b1111;
    push(4'b0000, 4'b1010, 4'b1111);
    wn(10);

    // reset while bit 2 is mid-count
    iKEY = 4'b1011;
    wn(2);
    RST_n = 1'b0;
    #1;
    chk("mid_rst_level", {28'd0, oKEY_LEVEL}, 32'hF);
    chk("mid_rst_press", {28'd0, oPRESS}, 32'h0);
    chk("mid_rst_release", {28'd0, oRELEASE}, 32'h0);
    iKEY = 4'b1111;
    wn(3);
    chk("mid_rst_level2", {28'd0, oKEY_LEVEL}, 32'hF);
    RST_n = 1'b1;
    wn(10);
    chk("post_rst_level", {28'd0, oKEY_LEVEL}, 32'hF);

    // long hold on bit 3
    begin
      int c0;
      c0 = cyc;
      iKEY = 4'b0111;
      push(4'b1000, 4'b0000, 4'b0111);
`ifdef KEY_AUTOREPEAT_EN
      for (int t = LAT + RD; t < LAT + 30; t += RP) begin
        push_at(c0 + t, 4'b1000, 4'b0000, 4'b0111);
      end
`endif
      wn(30);
      iKEY = 4'b1111;
      push(4'b0000, 4'b1000, 4'b1111);
      wn(12);
    end

    chk("queue_empty", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
